// File: rtl/mvau_pkg.sv
// rtl/mvau_pkg.sv - shared types and helpers for the MVAU weight loader
package mvau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvau_weight_mem_rw.sv
// rtl/mvau_weight_mem_rw.sv - one-write, one-registered-read weight RAM, read-first
module mvau_weight_mem_rw
  import mvau_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 4,
  parameter int ADDR_BW = 4
) (
  input  logic               aclk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_BW-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [ADDR_BW-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  localparam int IDX_BW = cnt_width(DEPTH);

  (* ram_style = "auto" *) logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset so a reset mid-load leaves earlier contents intact.
  always_ff @(posedge aclk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr[IDX_BW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < DEPTH) begin
      rd_data <= mem[rd_addr[IDX_BW-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/mvau_weight_loader.sv
// rtl/mvau_weight_loader.sv - streams a full weight set into PE memories
module mvau_weight_loader
  import mvau_pkg::*;
#(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int PE           = 2,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic                       in_wgt_v,
  input  logic [SIMD*TW-1:0]         in_wgt,
  output logic                       in_wgt_rdy,
  input  logic [WMEM_ADDR_BW-1:0]    wmem_addr,
  output logic [PE*SIMD*TW-1:0]      wmem_out,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       wmem_valid
);

  localparam int WW    = SIMD * TW;
  localparam int PE_BW = cnt_width(PE);
  localparam logic [PE_BW-1:0]        PE_LAST   = PE_BW'(PE - 1);
  localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  load_state_e               state_q, state_d;
  logic [PE_BW-1:0]          pe_cnt;
  logic [WMEM_ADDR_BW-1:0]   addr_cnt;
  logic                      hs;
  logic                      last_word;

  // Reset wins over a handshake landing in the same cycle.
  assign hs        = in_wgt_v && (state_q == ST_LOAD) && !rst;
  assign last_word = (pe_cnt == PE_LAST) && (addr_cnt == ADDR_LAST);

  always_ff @(posedge aclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_wgt_rdy = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      ST_IDLE: if (load_start) state_d = ST_LOAD;
      ST_LOAD: begin
        in_wgt_rdy = 1'b1;
        load_busy  = 1'b1;
        if (in_wgt_v && last_word) state_d = ST_DONE;
      end
      ST_DONE: begin
        load_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      pe_cnt     <= '0;
      addr_cnt   <= '0;
      wmem_valid <= 1'b0;
    end else if (state_q == ST_IDLE && load_start) begin
      pe_cnt     <= '0;
      addr_cnt   <= '0;
      wmem_valid <= 1'b0;
    end else if (hs) begin
      if (pe_cnt == PE_LAST) begin
        pe_cnt   <= '0;
        addr_cnt <= addr_cnt + 1'b1;
      end else begin
        pe_cnt   <= pe_cnt + 1'b1;
      end
    end else if (state_q == ST_DONE) begin
      wmem_valid <= 1'b1;
    end
  end

  for (genvar p = 0; p < PE; p++) begin : g_pe_mem
    mvau_weight_mem_rw #(
      .WIDTH   (WW),
      .DEPTH   (WMEM_DEPTH),
      .ADDR_BW (WMEM_ADDR_BW)
    ) u_mem (
      .aclk    (aclk),
      .rst     (rst),
      .wr_en   (hs && (pe_cnt == PE_BW'(p))),
      .wr_addr (addr_cnt),
      .wr_data (in_wgt),
      .rd_addr (wmem_addr),
      .rd_data (wmem_out[p*WW +: WW])
    );
  end

endmodule

// File: tb/tb_mvau_weight_loader.sv
// tb/tb_mvau_weight_loader.sv - randomized self-checking bench for mvau_weight_loader
module tb_mvau_weight_loader;

  localparam int SIMD  = 2;
  localparam int TW    = 1;
  localparam int PE    = 2;
  localparam int DEPTH = 4;
  localparam int ABW   = 4;
  localparam int WW    = SIMD * TW;
  localparam int NW    = PE * DEPTH;

  logic              aclk = 1'b0;
  logic              rst;
  logic              load_start;
  logic              in_wgt_v;
  logic [WW-1:0]     in_wgt;
  logic              in_wgt_rdy;
  logic [ABW-1:0]    wmem_addr;
  logic [PE*WW-1:0]  wmem_out;
  logic              load_busy;
  logic              load_done;
  logic              wmem_valid;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] model_mem [PE][DEPTH];
  logic          model_valid;
  logic [WW-1:0] words [NW];
  int            busy_n;

  always #5 aclk = ~aclk;

  mvau_weight_loader #(
    .SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW)
  ) dut (
    .aclk       (aclk),
    .rst        (rst),
    .load_start (load_start),
    .in_wgt_v   (in_wgt_v),
    .in_wgt     (in_wgt),
    .in_wgt_rdy (in_wgt_rdy),
    .wmem_addr  (wmem_addr),
    .wmem_out   (wmem_out),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .wmem_valid (wmem_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PE*WW-1:0] exp_word(input int a);
    logic [PE*WW-1:0] r;
    for (int p = 0; p < PE; p++) r[p*WW +: WW] = model_mem[p][a];
    return r;
  endfunction

  // Word k of a load lands in PE k%PE at address k/PE.
  task automatic run_load(input logic [WW-1:0] w [NW], input int vmode, input int start_at,
                          input int abort_at, input int rf_at, output int busy_cycles);
    int idx = 0;
    int iter = 0;
    int busy = 0;
    bit v;
    bit rf_pending = 0;
    logic [PE*WW-1:0] rf_exp = '0;
    @(negedge aclk) load_start = 1'b1;
    model_valid = 1'b0;
    @(negedge aclk) load_start = 1'b0;
    check_eq("valid_cleared", wmem_valid, 0);
    while (idx < NW && iter < 200) begin
      if (rf_pending) begin
        check_eq("read_first_old", wmem_out, rf_exp);
        rf_pending = 0;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        in_wgt_v = 1'b0;
        @(negedge aclk) rst = 1'b0;
        check_eq("abort_busy", load_busy, 0);
        check_eq("abort_rdy", in_wgt_rdy, 0);
        check_eq("abort_valid", wmem_valid, 0);
        check_eq("abort_out", wmem_out, 0);
        busy_cycles = busy;
        return;
      end
      if (load_busy) busy++;
      load_start = (iter == start_at);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (iter % 2 == 0);
        default: v = 1'($urandom_range(1, 0));
      endcase
      if (idx == rf_at) v = 1'b1;
      in_wgt_v = v;
      in_wgt   = w[idx];
      if (in_wgt_rdy && v) begin
        if (idx == rf_at) begin
          wmem_addr  = ABW'(idx / PE);
          rf_exp     = exp_word(idx / PE);
          rf_pending = 1;
        end
        model_mem[idx % PE][idx / PE] = w[idx];
        idx++;
      end
      iter++;
      @(negedge aclk);
    end
    in_wgt_v   = 1'b0;
    load_start = 1'b0;
    busy_cycles = busy;
    check_eq("word_count", idx, NW);
    check_eq("done_pulse", load_done, 1);
    check_eq("done_rdy", in_wgt_rdy, 0);
    check_eq("done_busy", load_busy, 0);
    @(negedge aclk);
    model_valid = 1'b1;
    check_eq("done_clear", load_done, 0);
    check_eq("valid_set", wmem_valid, 1);
  endtask

  task automatic read_all(input string tag);
    check_eq({tag, "_valid"}, wmem_valid, model_valid);
    for (int a = 0; a < DEPTH; a++) begin
      wmem_addr = ABW'(a);
      @(negedge aclk);
      check_eq($sformatf("%s_rd%0d", tag, a), wmem_out, exp_word(a));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; in_wgt_v = 1'b0; in_wgt = '0; wmem_addr = '0;
    model_valid = 1'b0;
    repeat (3) @(negedge aclk);
    check_eq("rst_rdy", in_wgt_rdy, 0);
    check_eq("rst_busy", load_busy, 0);
    check_eq("rst_done", load_done, 0);
    check_eq("rst_valid", wmem_valid, 0);
    check_eq("rst_out", wmem_out, 0);
    rst = 1'b0;
    @(negedge aclk);
    check_eq("idle_rdy", in_wgt_rdy, 0);

    for (int k = 0; k < NW; k++) words[k] = WW'(k);
    run_load(words, 0, -1, -1, -1, busy_n);
    check_eq("busy_cont", busy_n, NW);
    read_all("seq");

    run_load(words, 1, -1, -1, -1, busy_n);
    check_eq("busy_gap", busy_n, 2 * NW - 1);
    read_all("gap");

    for (int k = 0; k < NW; k++) words[k] = WW'($urandom);
    run_load(words, 2, -1, 3, -1, busy_n);
    read_all("abort");
    for (int k = 0; k < NW; k++) words[k] = WW'(3);
    run_load(words, 2, -1, -1, -1, busy_n);
    read_all("reload3");

    for (int k = 0; k < NW; k++) words[k] = WW'($urandom);
    run_load(words, 2, 3, -1, -1, busy_n);
    read_all("restart");

    for (int k = 0; k < NW; k++) words[k] = ~model_mem[k % PE][k / PE];
    run_load(words, 0, -1, -1, 2, busy_n);
    read_all("rfirst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
